// File: rtl/adc_spi_reader_if.sv
// Request/result handshake plus ADC pin bundle for adc_spi_reader.
// master = reader side, slave = scheduler/board side.
interface adc_spi_reader_if #(
  parameter int DATA_BITS = 12
);
  logic                 adc_start;
  logic                 adc_busy;
  logic                 adc_done;
  logic [DATA_BITS-1:0] adc_data;
  logic                 adc_cs_n;
  logic                 adc_sclk;
  logic                 adc_sdo;

  modport master (
    input  adc_start, adc_sdo,
    output adc_busy, adc_done, adc_data, adc_cs_n, adc_sclk
  );

  modport slave (
    output adc_start, adc_sdo,
    input  adc_busy, adc_done, adc_data, adc_cs_n, adc_sclk
  );
endinterface

// File: rtl/adc_spi_reader.sv
// SPI ADC frame reader (AD7476-class); ADC_AVG_EN averages 4 frames per request.
// Latency: adc_done (2+2*FRAME_BITS)*CLK_DIV cycles after cs_n falls (x4 with ADC_AVG_EN).
// No backpressure: start edges arriving while busy are dropped, never queued.
module adc_spi_reader #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12
) (
  input logic              sys_clk,
  input logic              rst_n,
  adc_spi_reader_if.master bus
);
  localparam int DIV_W = $clog2(2*CLK_DIV + 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam logic [DIV_W-1:0] HALF_END = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] FULL_END = DIV_W'(2*CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t               state, state_nxt;
  logic [DIV_W-1:0]     div, div_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data, data_nxt;
  logic                 busy, busy_nxt;
  logic                 done, done_nxt;
  logic                 cs_n, cs_n_nxt;
  logic                 sclk, sclk_nxt;
  logic                 adc_start_d;
  logic                 start_evt;
`ifdef ADC_AVG_EN
  logic [DATA_BITS+1:0] acc, acc_nxt;
  logic [1:0]           frame, frame_nxt;
`endif

  assign start_evt = bus.adc_start & ~adc_start_d;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      data        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cs_n        <= 1'b1;
      sclk        <= 1'b1;
      adc_start_d <= 1'b0;
`ifdef ADC_AVG_EN
      acc         <= '0;
      frame       <= '0;
`endif
    end else begin
      state       <= state_nxt;
      div         <= div_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shift       <= shift_nxt;
      data        <= data_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      cs_n        <= cs_n_nxt;
      sclk        <= sclk_nxt;
      adc_start_d <= bus.adc_start;
`ifdef ADC_AVG_EN
      acc         <= acc_nxt;
      frame       <= frame_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    div_nxt     = div;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    data_nxt    = data;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    cs_n_nxt    = cs_n;
    sclk_nxt    = sclk;
`ifdef ADC_AVG_EN
    acc_nxt     = acc;
    frame_nxt   = frame;
`endif
    case (state)
      IDLE: begin
        if (start_evt) begin
          state_nxt = SETUP;
          cs_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          div_nxt   = '0;
`ifdef ADC_AVG_EN
          acc_nxt   = '0;
          frame_nxt = '0;
`endif
        end
      end
      SETUP: begin
        if (div == HALF_END) begin
          state_nxt   = SHIFT;
          div_nxt     = '0;
          bit_cnt_nxt = '0;
          sclk_nxt    = 1'b0;
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      SHIFT: begin
        div_nxt = div + 1'b1;
        // Leading frame bits fall off the top, leaving the last DATA_BITS.
        if (div == HALF_END) begin
          sclk_nxt  = 1'b1;
          shift_nxt = {shift[DATA_BITS-2:0], bus.adc_sdo};
        end else if (div == FULL_END) begin
          div_nxt = '0;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = HOLD;
            cs_n_nxt  = 1'b1;
`ifdef ADC_AVG_EN
            acc_nxt   = acc + {2'b00, shift};
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            sclk_nxt    = 1'b0;
          end
        end
      end
      HOLD: begin
        if (div == HALF_END) begin
          div_nxt = '0;
`ifdef ADC_AVG_EN
          // HOLD doubles as the quiet time between the four frames.
          if (frame == 2'd3) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            data_nxt  = acc[DATA_BITS+1:2];
          end else begin
            frame_nxt = frame + 1'b1;
            state_nxt = SETUP;
            cs_n_nxt  = 1'b0;
          end
`else
          state_nxt = DONE;
          done_nxt  = 1'b1;
          data_nxt  = shift;
`endif
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.adc_busy = busy;
  assign bus.adc_done = done;
  assign bus.adc_data = data;
  assign bus.adc_cs_n = cs_n;
  assign bus.adc_sclk = sclk;
endmodule
